// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time, holds the fetched word for decode.
// Optional define FETCH_MISALIGN_TRAP_EN: halt with a sticky flag on a next PC with bit[1] set.
module fetch_pc_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    output logic            misaligned
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] npc_raw;
    logic [XLEN-1:0] npc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            mis_q, mis_d;
`endif

    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        npc_raw = pc_plus4;
        case (PCSrc)
            2'b01:   npc_raw = pc_q + imm_ext;
            2'b10:   npc_raw = alu_result & ~XLEN'(1);
            default: npc_raw = pc_plus4;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        npc = npc_raw;
`else
        npc = npc_raw & ~XLEN'(3);
`endif
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        drop_d  = drop_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (!drop_q && imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid && !drop_q) begin
                    instr_d = imem_rsp_data;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_d    = npc;
                    state_d = S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (npc[1]) begin
                        mis_d   = 1'b1;
                        state_d = S_HALT;
                    end
`endif
                end
            end
            default: state_d = state_q;
        endcase
        // A stale response may land in any state once the drop flag is armed.
        if (drop_q && imem_rsp_valid) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            drop_q  <= (state_q == S_WAIT);
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            drop_q  <= drop_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign imem_req_valid = (state_q == S_REQ) && !drop_q;
    assign imem_addr      = pc_q;
    assign instr_valid    = (state_q == S_HOLD);
    assign instr          = instr_q;
    assign instr_pc       = pc_q;
    assign instr_pc_plus4 = pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned     = mis_q;
`else
    assign misaligned     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomised bench for fetch_pc_unit: transaction-level reference model plus directed literal checks.
module tb_fetch_pc_unit;

    localparam int          XLEN   = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic [1:0]  PCSrc;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        misaligned;

    always #5 clk = ~clk;

    fetch_pc_unit #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .PCSrc          (PCSrc),
        .imm_ext        (imm_ext),
        .alu_result     (alu_result),
        .misaligned     (misaligned)
    );

    int n_vec = 0;
    int n_err = 0;

    // stimulus knobs
    int          k_rdy, k_dmin, k_dmax, k_ir, k_rst, stall;
    bit          k_tab;
    logic [1:0]  t_src [8];
    logic [31:0] t_imm [8];
    logic [31:0] t_alu [8];
    bit          force_pending;
    int          force_cyc;

    // reference model: where the fetch stage must be in its transaction
    bit          known, m_idle, m_reqph, m_out, m_hold, m_drop, m_mis;
    logic [31:0] m_pc, m_word;
    int          n_cons;

    // memory and observation log
    int          pend, serial, cyc;
    logic [31:0] pend_data;
    bit          last_rst, prev_iv, p4_got;
    logic [31:0] p4_seen;
    logic [31:0] acc_a[$], acc_c[$], iv_c[$], w_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] src,
                                               input logic [31:0] imm, input logic [31:0] alu);
        case (src)
            2'b01:   return pc + imm;
            2'b10:   return alu & 32'hFFFF_FFFE;
            default: return pc + 32'd4;
        endcase
    endfunction

    task automatic step();
        logic        rsp_now, rst_now, rdy, ir;
        logic [1:0]  src;
        logic [31:0] imm, alu, raw, data, tmp;
        int          off;
        @(negedge clk);
        cyc = last_rst ? 1 : cyc + 1;
        if (known) begin
            chk("req_valid", 32'(imem_req_valid), 32'(m_reqph && !m_drop));
            chk("instr_valid", 32'(instr_valid), 32'(m_hold));
            chk("imem_addr", imem_addr, m_pc);
            chk("misaligned", 32'(misaligned), 32'(m_mis));
            if (m_hold) begin
                chk("instr", instr, m_word);
                chk("instr_pc", instr_pc, m_pc);
                chk("instr_pc_plus4", instr_pc_plus4, m_pc + 32'd4);
            end
        end
        rsp_now = (pend == 1);
        if (pend > 0) pend--;
        data = rsp_now ? pend_data : $urandom();
        if (force_pending && (force_cyc == 0 || cyc == force_cyc)) begin
            rst_now = 1'b1;
            force_pending = 1'b0;
        end else begin
            rst_now = !rsp_now && (int'($urandom_range(999)) < k_rst);
        end
        rdy = !rst_now && (pend == 0) && (int'($urandom_range(99)) < k_rdy);
        if (stall > 0) begin
            rdy = 1'b0;
            stall--;
        end
        ir = int'($urandom_range(99)) < k_ir;
        if (k_tab && n_cons < 8) begin
            src = t_src[n_cons];
            imm = t_imm[n_cons];
            alu = t_alu[n_cons];
        end else begin
            src = 2'($urandom_range(3));
            off = int'($urandom_range(64)) - 32;
            imm = ($urandom_range(7) == 0) ? $urandom() : 32'(off * 4);
            tmp = $urandom();
            alu = ($urandom_range(3) == 0) ? tmp : (tmp & 32'hFFFF_FFFC);
        end
        rst            = rst_now;
        imem_req_ready = rdy;
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = data;
        instr_ready    = ir;
        PCSrc          = src;
        imm_ext        = imm;
        alu_result     = alu;

        if (imem_req_valid === 1'b1 && rdy) begin
            acc_a.push_back(imem_addr);
            acc_c.push_back(32'(cyc));
            pend = k_dmin + int'($urandom_range(k_dmax - k_dmin));
            serial++;
            pend_data = {imem_addr[15:0], 16'(serial)};
        end
        if (instr_valid === 1'b1 && !prev_iv) begin
            iv_c.push_back(32'(cyc));
            w_q.push_back(instr);
        end
        prev_iv = (instr_valid === 1'b1);
        if (instr_valid === 1'b1 && instr_pc == 32'hFFFF_FFFC) begin
            p4_got  = 1'b1;
            p4_seen = instr_pc_plus4;
        end

        if (rst_now) begin
            m_drop  = known && m_out;
            m_idle  = 1'b1;
            m_reqph = 1'b0;
            m_out   = 1'b0;
            m_hold  = 1'b0;
            m_mis   = 1'b0;
            m_pc    = RST_PC;
            m_word  = NOP;
            n_cons  = 0;
            known   = 1'b1;
        end else if (known) begin
            if (m_idle) begin
                m_idle  = 1'b0;
                m_reqph = 1'b1;
            end else if (m_reqph) begin
                if (!m_drop && rdy) begin
                    m_reqph = 1'b0;
                    m_out   = 1'b1;
                end
            end else if (m_out) begin
                if (rsp_now && !m_drop) begin
                    m_word = data;
                    m_out  = 1'b0;
                    m_hold = 1'b1;
                end
            end else if (m_hold && ir) begin
                raw    = model_next(m_pc, src, imm, alu);
                n_cons++;
                m_hold = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                m_pc = raw;
                if (raw[1]) m_mis = 1'b1;
                else        m_reqph = 1'b1;
`else
                m_pc    = raw & 32'hFFFF_FFFC;
                m_reqph = 1'b1;
`endif
            end
            if (m_drop && rsp_now) m_drop = 1'b0;
        end
        last_rst = rst_now;
    endtask

    // Drain any in-flight memory response, then reset from REQ so the drop flag is clear.
    task automatic begin_phase();
        k_rdy = 0;
        k_rst = 0;
        stall = 0;
        repeat (6) step();
        force_pending = 1'b1;
        force_cyc     = 0;
        step();
        acc_a.delete();
        acc_c.delete();
        iv_c.delete();
        w_q.delete();
        p4_got  = 1'b0;
        p4_seen = 'x;
        k_rdy = 100;
        k_dmin = 1;
        k_dmax = 1;
        k_ir  = 100;
        k_tab = 1'b1;
        for (int i = 0; i < 8; i++) begin
            t_src[i] = 2'b00;
            t_imm[i] = '0;
            t_alu[i] = '0;
        end
    endtask

    initial begin
        int s0;
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        instr_ready = 1'b0; PCSrc = 2'b00; imm_ext = '0; alu_result = '0;
        known = 1'b0; pend = 0; serial = 0; cyc = 0; last_rst = 1'b0; prev_iv = 1'b0;
        force_pending = 1'b0; force_cyc = 0; k_tab = 1'b0;
        k_rdy = 0; k_dmin = 1; k_dmax = 1; k_ir = 0; k_rst = 0; stall = 0;
        m_idle = 0; m_reqph = 0; m_out = 0; m_hold = 0; m_drop = 0; m_mis = 0;
        m_pc = RST_PC; m_word = NOP; n_cons = 0; p4_got = 0; p4_seen = 'x;

        // reset values
        begin_phase();
        step();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, RST_PC);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_misaligned", 32'(misaligned), 32'd0);

        // zero-wait sequential fetch
        begin_phase();
        repeat (11) step();
        chk("seq_addr0", qget(acc_a, 0), 32'h0);
        chk("seq_addr1", qget(acc_a, 1), 32'h4);
        chk("seq_addr2", qget(acc_a, 2), 32'h8);
        chk("seq_req_cyc0", qget(acc_c, 0), 32'd2);
        chk("seq_iv_cyc0", qget(iv_c, 0), 32'd4);
        chk("seq_iv_cyc1", qget(iv_c, 1), 32'd7);
        chk("seq_iv_cyc2", qget(iv_c, 2), 32'd10);

        // ready held low 5 cycles, response delayed 4
        begin_phase();
        stall = 6;
        k_dmin = 4;
        k_dmax = 4;
        repeat (14) step();
        chk("stall_accept_cyc", qget(acc_c, 0), 32'd7);
        chk("stall_accept_addr", qget(acc_a, 0), 32'h0);
        chk("stall_iv_cyc", qget(iv_c, 0), 32'd12);

        // branch back, jalr, then misaligned jalr target
        begin_phase();
        t_src[4] = 2'b01; t_imm[4] = 32'hFFFF_FFF8;
        t_src[5] = 2'b10; t_alu[5] = 32'h0000_0101;
        t_src[6] = 2'b10; t_alu[6] = 32'h0000_0106;
        repeat (30) step();
        chk("branch_addr", qget(acc_a, 5), 32'h08);
        chk("jalr_addr", qget(acc_a, 6), 32'h100);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("trap_req_count", 32'(acc_a.size()), 32'd7);
        chk("trap_misaligned", 32'(misaligned), 32'd1);
        chk("trap_req_valid", 32'(imem_req_valid), 32'd0);
`else
        chk("align_addr", qget(acc_a, 7), 32'h104);
        chk("align_misaligned", 32'(misaligned), 32'd0);
`endif

        // PC wrap at the top of the address space
        begin_phase();
        t_src[0] = 2'b10; t_alu[0] = 32'hFFFF_FFFC;
        repeat (12) step();
        chk("wrap_addr1", qget(acc_a, 1), 32'hFFFF_FFFC);
        chk("wrap_addr2", qget(acc_a, 2), 32'h0);
        chk("wrap_seen", 32'(p4_got), 32'd1);
        chk("wrap_plus4", p4_seen, 32'h0);

        // reset while waiting: stale response dropped, no request until it lands
        begin_phase();
        k_dmin = 3;
        k_dmax = 3;
        s0 = serial;
        force_pending = 1'b1;
        force_cyc     = 3;
        repeat (14) step();
        chk("drop_req_cyc0", qget(acc_c, 0), 32'd2);
        chk("drop_req_cyc1", qget(acc_c, 1), 32'd3);
        chk("drop_req_addr1", qget(acc_a, 1), RST_PC);
        chk("drop_word", qget(w_q, 0), {RST_PC[15:0], 16'(s0 + 2)});

        // randomized traffic against the model
        begin_phase();
        k_tab  = 1'b0;
        k_rdy  = 70;
        k_dmin = 1;
        k_dmax = 4;
        k_ir   = 60;
        k_rst  = 10;
        repeat (3000) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the single-cycle RISC-V core, directly upstream of the main instruction decoder. Owns the program counter and issues one request at a time to instruction memory over a valid/ready request and valid response interface. Presents the fetched word, with its PC and PC+4, to decode/execute. On consumption, selects the next PC from the decoder's 2-bit `PCSrc`.

## Interface
- `XLEN`, 32: address/PC width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset. Must be 4-byte aligned.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_addr` out XLEN: fetch address; equals the current PC.
- `imem_rsp_valid` in 1: response word valid.
- `imem_rsp_data` in 32: instruction word.
- `instr_valid` out 1: `instr`, `instr_pc` and `instr_pc_plus4` are valid.
- `instr_ready` in 1: the core executes the held instruction this cycle.
- `instr` out 32: held instruction.
- `instr_pc` out XLEN: PC of `instr`.
- `instr_pc_plus4` out XLEN: `instr_pc + 4`, modulo 2^XLEN.
- `PCSrc` in 2: next-PC select from the decoder. Sampled only on the consume cycle.
- `imm_ext` in XLEN: sign-extended branch/jal offset.
- `alu_result` in XLEN: jalr target.
- `misaligned` out 1: sticky misaligned-target flag (see Configuration).

## Operation
- States are IDLE, REQ, WAIT, HOLD and HALT.
- **IDLE:** entered on reset. Moves to REQ on the next cycle.
- **REQ:**
  - `imem_req_valid`=1 and `imem_addr`=PC.
  - On `imem_req_ready`=1 the request is accepted and the state moves to WAIT.
  - Valid is held, with a stable address, until accepted.
- **WAIT:**
  - On `imem_rsp_valid`=1 (and no drop pending), `imem_rsp_data` is captured into `instr` and the state moves to HOLD.
  - The response may arrive no earlier than the cycle after acceptance.
- **HOLD:**
  - `instr_valid`=1. Outputs are stable until consumed.
  - On `instr_ready`=1, the PC is loaded with the next PC and the state moves to REQ.
- Next PC, with all arithmetic modulo 2^XLEN:
  - `PCSrc`=00: PC+4.
  - `PCSrc`=01: PC+`imm_ext`.
  - `PCSrc`=10: `alu_result` & ~1.
  - `PCSrc`=11: reserved; treated as PC+4.
- One outstanding request maximum.
- `imem_rsp_valid` is ignored in IDLE, REQ, HOLD and HALT.
- **Drop pending:**
  - If `rst` is asserted while in WAIT, a one-bit drop flag is set.
  - The first later `imem_rsp_valid` is discarded and clears the flag.
  - REQ does not assert `imem_req_valid` while drop is pending.
  - `rst` in any other state clears the flag.
- Reset values:
  - State IDLE and PC=`RESET_PC`.
  - `imem_req_valid`=0, `instr_valid`=0, `instr`=32'h0000_0013 (NOP).
  - `instr_pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, `misaligned`=0.

## Timing
- Reset release at edge N puts the block in IDLE in cycle N. REQ is asserted in N+1.
- Zero-wait memory (ready=1, response the cycle after acceptance):
  - REQ at cycle N+1, WAIT at N+2 with the response captured, HOLD with `instr_valid` at N+3.
  - Steady state is one instruction per 3 cycles.
- `instr_valid` deasserts the cycle after the consume cycle. The new `imem_addr` is visible that same cycle.
- `rst` is sampled at the clock edge and overrides every state transition, including a simultaneous consume or response.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - If the selected next PC has bit[1] set, the PC loads the target unchanged.
  - `misaligned`=1 and the state moves to HALT.
  - HALT issues no requests and keeps `instr_valid`=0. It is left only by `rst`.
- Not defined:
  - The next PC has bits[1:0] forced to 0 and `misaligned` is tied to 0.
  - HALT is unreachable.

## Test plan
- Reset with `RESET_PC`=0, zero-wait memory returning 0x00000013 and `instr_ready`=1, `PCSrc`=00 → fetch addresses 0x0, 0x4, 0x8, and `instr_valid` every 3rd cycle.
- Memory holds ready low for 5 cycles and delays the response by 4 → `imem_addr` stays stable throughout, and `instr_valid` rises only after the response.
- Branch at PC=0x10 with `PCSrc`=01 and `imm_ext`=0xFFFFFFF8 → next fetch 0x08. jalr with `PCSrc`=10 and `alu_result`=0x101 → next fetch 0x100.
- PC=0xFFFFFFFC with `PCSrc`=00 → next fetch 0x0. `instr_pc_plus4` reads 0x0.
- `rst` pulsed in WAIT, then the stale response arrives → the stale word is dropped and the next captured word comes from `RESET_PC`.
- With `FETCH_MISALIGN_TRAP_EN`: `PCSrc`=10 and `alu_result`=0x106 → `misaligned`=1 and no further requests. Without it, the next fetch is 0x104 and `misaligned`=0.
